// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 pipeline sequencer: FSM encoding,
// zero-register index, stage-valid bit positions and source-use opcode patterns.
package legv8_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_t;

  localparam logic [4:0] XZR = 5'd31;

  localparam int SV_ID  = 0;
  localparam int SV_EX  = 1;
  localparam int SV_MEM = 2;
  localparam int SV_WB  = 3;

  // R-format ALU ops: 1xx0101x000
  localparam logic [10:0] OP_RFMT_VAL  = 11'b10001010000;
  localparam logic [10:0] OP_RFMT_MASK = 11'b10011110111;
  localparam logic [10:0] OP_LDUR      = 11'b11111000010;
  localparam logic [10:0] OP_STUR      = 11'b11111000000;
  // CBZ: 10110100xxx
  localparam logic [10:0] OP_CBZ_VAL   = 11'b10110100000;
  localparam logic [10:0] OP_CBZ_MASK  = 11'b11111111000;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/src_decode.sv
// Decodes which source register fields the IF/ID instruction actually reads.
module src_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output logic        use_rn,
  output logic        use_rm,
  output logic        use_rt
);

  // pure opcode-pattern decode; unmatched opcodes read no registers
  always_comb begin
    use_rn = 1'b0;
    use_rm = 1'b0;
    use_rt = 1'b0;
    if (op_match(opcode, OP_RFMT_VAL, OP_RFMT_MASK)) begin
      use_rn = 1'b1;
      use_rm = 1'b1;
    end else if (opcode == OP_LDUR) begin
      use_rn = 1'b1;
    end else if (opcode == OP_STUR) begin
      use_rn = 1'b1;
      use_rt = 1'b1;
    end else if (op_match(opcode, OP_CBZ_VAL, OP_CBZ_MASK)) begin
      use_rt = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control sequencer: load-use stall and taken-branch flush.
//
//   state | meaning
//   HOLD  | post-reset, all enables off, moves to RUN next cycle
//   RUN   | normal flow; hazard -> STALL, taken branch -> FLUSH
//   STALL | one cycle after a load-use bubble, RUN outputs
//   FLUSH | one cycle after a branch flush, MEM branch ignored
module pipeline_sequencer
  import legv8_pkg::*;
#(
  parameter int         CNT_W = 16,
  parameter logic [4:0] XZR   = legv8_pkg::XZR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [10:0]      id_opcode,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [3:0]       stage_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  seq_state_t state_q, state_d;
  logic use_rn, use_rm, use_rt;
  logic src_match, hazard, branch;

  src_decode u_src_decode (
    .opcode (id_opcode),
    .use_rn (use_rn),
    .use_rm (use_rm),
    .use_rt (use_rt)
  );

  assign src_match = (use_rn && (ex_rd == id_rn)) ||
                     (use_rm && (ex_rd == id_rm)) ||
                     (use_rt && (ex_rd == id_rt));
  assign hazard = ex_memread && stage_valid[SV_EX] && stage_valid[SV_ID] &&
                  (ex_rd != XZR) && src_match;
  // FLUSH holds a bubble in EX/MEM, so a branch seen there is stale
  assign branch = mem_branch_taken && (state_q == ST_RUN || state_q == ST_STALL);
  assign state  = state_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_HOLD;
    else     state_q <= state_d;
  end

  // next-state: branch beats hazard
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD:  state_d = ST_RUN;
      ST_RUN:   state_d = branch ? ST_FLUSH : (hazard ? ST_STALL : ST_RUN);
      ST_STALL: state_d = branch ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
    endcase
  end

  // outputs: reset and HOLD keep everything low; hazard outranks imem_ready
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    if (!rst && state_q != ST_HOLD) begin
      if (branch) begin
        pc_write    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end else if (hazard) begin
        idex_bubble = 1'b1;
      end else begin
        pc_write   = imem_ready;
        ifid_write = imem_ready;
        ifid_flush = ~imem_ready;
      end
    end
  end

  // stage valid bits follow the pipeline register enables and flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
    end else begin
      stage_valid[SV_ID]  <= ifid_flush ? 1'b0 :
                             (ifid_write ? imem_ready : stage_valid[SV_ID]);
      stage_valid[SV_EX]  <= stage_valid[SV_ID] & ~idex_bubble;
      stage_valid[SV_MEM] <= stage_valid[SV_EX] & ~exmem_flush;
      stage_valid[SV_WB]  <= stage_valid[SV_MEM];
    end
  end

  // saturating event counters; only RUN can start a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state_q == ST_RUN && hazard && !branch && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scenario bench for pipeline_sequencer; a 4-bit-counter copy shares the
// stimulus so counter saturation is reachable quickly.
module tb_pipeline_sequencer;

  localparam logic [1:0] HOLD = 2'd0, RUN = 2'd1, STALL = 2'd2, FLUSH = 2'd3;
  localparam logic [10:0] NOP  = 11'b00000000000;
  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  // ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}
  localparam logic [4:0] C_OFF = 5'b00000, C_RUN = 5'b11000, C_HAZ = 5'b00010;
  localparam logic [4:0] C_BR  = 5'b10111, C_NRDY = 5'b00100;

  typedef struct packed {
    logic rst, ir, bt, mr;
    logic [4:0] rd;
    logic [10:0] op;
    logic [4:0] rn, rm, rt;
  } stim_t;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [3:0]  sv;
    logic [15:0] sc, fc;
    logic [3:0]  scs, fcs;
  } obs_t;

  logic clk = 1'b0;
  logic rst, imem_ready, ex_memread, mem_branch_taken;
  logic [10:0] id_opcode;
  logic [4:0] id_rn, id_rm, id_rt, ex_rd;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
  logic [3:0] stage_valid;
  logic [1:0] state;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush;
  logic [3:0] s_stage_valid;
  logic [1:0] s_state;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  obs_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .id_opcode(id_opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_flush(exmem_flush), .stage_valid(stage_valid), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_sequencer #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .id_opcode(id_opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .exmem_flush(s_exmem_flush), .stage_valid(s_stage_valid), .state(s_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic stim_t S(input logic r, ir, bt, mr, input logic [4:0] rd,
                              input logic [10:0] op, input logic [4:0] rn, rm, rt);
    stim_t s;
    s.rst = r; s.ir = ir; s.bt = bt; s.mr = mr; s.rd = rd;
    s.op = op; s.rn = rn; s.rm = rm; s.rt = rt;
    return s;
  endfunction

  function automatic obs_t E(input logic [4:0] ctl, input logic [1:0] st,
                             input logic [3:0] sv, input int sc, input int fc);
    obs_t e;
    e.ctl = ctl; e.st = st; e.sv = sv;
    e.sc = sc[15:0]; e.fc = fc[15:0];
    e.scs = (sc > 15) ? 4'hF : sc[3:0];
    e.fcs = (fc > 15) ? 4'hF : fc[3:0];
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush};
    o.st = state; o.sv = stage_valid; o.sc = stall_cnt; o.fc = flush_cnt;
    o.scs = s_stall_cnt; o.fcs = s_flush_cnt;
    return o;
  endfunction

  // drive one cycle of stimulus and queue its expected observation
  task automatic apply(input stim_t s, input obs_t e);
    rst = s.rst; imem_ready = s.ir; mem_branch_taken = s.bt; ex_memread = s.mr;
    ex_rd = s.rd; id_opcode = s.op; id_rn = s.rn; id_rm = s.rm; id_rt = s.rt;
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, ex;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      apply(S(1, 1, 1, 1, 9, ADD, 9, 2, 0), E(C_OFF, HOLD, 4'b0000, 0, 0));
      got = observe(); ex = sb.pop_front(); n_assert++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fill();
    stim_t s[$]; obs_t e[$]; obs_t got, ex;
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_OFF, HOLD, 4'b0000, 0, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN, 4'b0000, 0, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN, 4'b0001, 0, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN, 4'b0011, 0, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN, 4'b0111, 0, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN, 4'b1111, 0, 0));
    foreach (s[i]) begin
      apply(s[i], e[i]);
      got = observe(); ex = sb.pop_front(); n_assert++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL fill[%0d]: got %h expected %h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; obs_t e[$]; obs_t got, ex;
    s.push_back(S(0,1,0,1,9,ADD,9,2,0)); e.push_back(E(C_HAZ, RUN,   4'b1111, 0, 0));
    s.push_back(S(0,1,0,1,9,ADD,9,2,0)); e.push_back(E(C_RUN, STALL, 4'b1101, 1, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN,   4'b1011, 1, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN,   4'b0111, 1, 0));
    foreach (s[i]) begin
      apply(s[i], e[i]);
      got = observe(); ex = sb.pop_front(); n_assert++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %h expected %h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_src_fields();
    stim_t s[$]; obs_t e[$]; obs_t got, ex;
    s.push_back(S(0,1,0,1,31,ADD,31,31,31)); e.push_back(E(C_RUN, RUN,   4'b1111, 1, 0));
    s.push_back(S(0,1,0,1,3,STUR,5,0,3));    e.push_back(E(C_HAZ, RUN,   4'b1111, 1, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0));     e.push_back(E(C_RUN, STALL, 4'b1101, 2, 0));
    s.push_back(S(0,1,0,1,3,LDUR,4,3,3));    e.push_back(E(C_RUN, RUN,   4'b1011, 2, 0));
    s.push_back(S(0,1,0,1,7,CBZ,0,0,7));     e.push_back(E(C_HAZ, RUN,   4'b0111, 2, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0));     e.push_back(E(C_RUN, STALL, 4'b1101, 3, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0));     e.push_back(E(C_RUN, RUN,   4'b1011, 3, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0));     e.push_back(E(C_RUN, RUN,   4'b0111, 3, 0));
    foreach (s[i]) begin
      apply(s[i], e[i]);
      got = observe(); ex = sb.pop_front(); n_assert++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL src_fields[%0d]: got %h expected %h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_imem_not_ready();
    stim_t s[$]; obs_t e[$]; obs_t got, ex;
    s.push_back(S(0,0,0,1,9,ADD,9,2,0)); e.push_back(E(C_HAZ,  RUN,   4'b1111, 3, 0));
    s.push_back(S(0,0,0,0,0,NOP,0,0,0)); e.push_back(E(C_NRDY, STALL, 4'b1101, 4, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN,  RUN,   4'b1010, 4, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN,  RUN,   4'b0101, 4, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN,  RUN,   4'b1011, 4, 0));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN,  RUN,   4'b0111, 4, 0));
    foreach (s[i]) begin
      apply(s[i], e[i]);
      got = observe(); ex = sb.pop_front(); n_assert++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL imem_not_ready[%0d]: got %h expected %h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; obs_t e[$]; obs_t got, ex;
    s.push_back(S(0,1,1,1,9,ADD,9,2,0)); e.push_back(E(C_BR,  RUN,   4'b1111, 4, 0));
    s.push_back(S(0,1,1,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, FLUSH, 4'b1000, 4, 1));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN,   4'b0001, 4, 1));
    s.push_back(S(0,1,0,1,9,ADD,9,2,0)); e.push_back(E(C_HAZ, RUN,   4'b0011, 4, 1));
    s.push_back(S(0,1,1,0,0,NOP,0,0,0)); e.push_back(E(C_BR,  STALL, 4'b0101, 5, 1));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, FLUSH, 4'b1000, 5, 2));
    foreach (s[i]) begin
      apply(s[i], e[i]);
      got = observe(); ex = sb.pop_front(); n_assert++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %h expected %h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    stim_t s[$]; obs_t e[$]; obs_t got, ex;
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN,   4'b0001, 5, 2));
    s.push_back(S(0,1,0,1,9,ADD,9,2,0)); e.push_back(E(C_HAZ, RUN,   4'b0011, 5, 2));
    s.push_back(S(1,1,0,1,9,ADD,9,2,0)); e.push_back(E(C_OFF, STALL, 4'b0101, 6, 2));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_OFF, HOLD,  4'b0000, 0, 0));
    s.push_back(S(0,1,1,0,0,NOP,0,0,0)); e.push_back(E(C_BR,  RUN,   4'b0000, 0, 0));
    s.push_back(S(1,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_OFF, FLUSH, 4'b0000, 0, 1));
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_OFF, HOLD,  4'b0000, 0, 0));
    foreach (s[i]) begin
      apply(s[i], e[i]);
      got = observe(); ex = sb.pop_front(); n_assert++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL reset_abort[%0d]: got %h expected %h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  // 20 back-to-back stalls then 20 flushes: the 4-bit copy must pin at 15
  task automatic test_saturation();
    stim_t s[$]; obs_t e[$]; obs_t got, ex;
    logic [3:0] fill_sv [4];
    fill_sv[0] = 4'b0000; fill_sv[1] = 4'b0001; fill_sv[2] = 4'b0011; fill_sv[3] = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN, fill_sv[i], 0, 0));
    end
    for (int i = 0; i < 20; i++) begin
      s.push_back(S(0,1,0,1,9,ADD,9,2,0));
      e.push_back(E(C_HAZ, RUN, (i == 0) ? 4'b1111 : 4'b1011, i, 0));
      s.push_back(S(0,1,0,1,9,ADD,9,2,0));
      e.push_back(E(C_RUN, STALL, (i == 0) ? 4'b1101 : 4'b0101, i + 1, 0));
    end
    for (int j = 0; j < 20; j++) begin
      s.push_back(S(0,1,1,0,0,NOP,0,0,0));
      e.push_back(E(C_BR, RUN, (j == 0) ? 4'b1011 : 4'b0001, 20, j));
      s.push_back(S(0,1,1,0,0,NOP,0,0,0));
      e.push_back(E(C_RUN, FLUSH, 4'b0000, 20, j + 1));
    end
    s.push_back(S(0,1,0,0,0,NOP,0,0,0)); e.push_back(E(C_RUN, RUN, 4'b0001, 20, 20));
    foreach (s[i]) begin
      apply(s[i], e[i]);
      got = observe(); ex = sb.pop_front(); n_assert++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got %h expected %h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; mem_branch_taken = 1'b0; ex_memread = 1'b0;
    ex_rd = '0; id_opcode = '0; id_rn = '0; id_rm = '0; id_rt = '0;
    test_reset();
    test_fill();
    test_load_use();
    test_src_fields();
    test_imem_not_ready();
    test_branch();
    test_reset_abort();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
